uart_flit_tx_queue: RTL
=======================

// Module: uart_flit_tx_queue
// PURPOSE
//  Buffers 16-bit NoC flits from a router egress port and feeds them one at a time to uart_tx.
//  Sits directly upstream of uart_tx and drives its tx_data/new_tx_data inputs.
//  Paces issue with tx_busy, so no flit is lost or overwritten while the serialiser is active.
// PARAMETERS
//  DATA_W   16  flit / tx_data width in bits
//  DEPTH    8   FIFO entries; power of two, >= 2
//  ADDR_W   $clog2(DEPTH)  pointer width (derived; do not override)
// PORTS
//  clock        in   1       system clock (100 MHz in the UART build)
//  reset        in   1       asynchronous, active-high; clears all state
//  flit_in      in   DATA_W  flit from router
//  flit_valid   in   1       flit_in valid
//  flit_ready   out  1       queue can accept; a push happens when flit_valid & flit_ready
//  tx_data      out  DATA_W  to uart_tx.tx_data; held stable from LOAD until the return to IDLE
//  new_tx_data  out  1       to uart_tx.new_tx_data; one-cycle pulse per flit
//  tx_busy      in   1       from uart_tx.tx_busy
//  count        out  ADDR_W+1  current FIFO occupancy, 0..DEPTH
//  empty        out  1       count==0
//  full         out  1       count==DEPTH
//  tx_count     out  16      flits issued; see CONFIGURATION
// BEHAVIOUR
//  Reset values: flit_ready=1, new_tx_data=0, tx_data=0, count=0, empty=1, full=0, tx_count=0, state=IDLE.
//  All outputs are registered except flit_ready, empty and full, which decode the registered count.
//  flit_ready = !full, so a push is never accepted when full, even if a pop happens in the same cycle.
//  Push and pop may occur in the same cycle when not full; count is then unchanged and the pointers wrap mod DEPTH.
//  FSM:
//   IDLE      : if !empty & !tx_busy -> LOAD
//   LOAD      : pop the head into tx_data; new_tx_data=1 for exactly this cycle -> WAIT_BUSY
//   WAIT_BUSY : new_tx_data=0; if tx_busy -> WAIT_DONE
//   WAIT_DONE : if !tx_busy -> IDLE
//  Latency: a push into an empty queue at edge N shows as count=1 after N.
//   The FSM enters LOAD at edge N+1 and new_tx_data is high in cycle N+1..N+2.
//  Back-to-back: the next LOAD comes no earlier than 1 cycle after tx_busy falls. IDLE is always visited.
//  tx_busy already high while in IDLE blocks issue; the FSM stays in IDLE.
//  WAIT_BUSY has no timeout. uart_tx asserts tx_busy on the cycle after new_tx_data, which is required.
//  An asynchronous reset mid-transfer aborts the transfer and discards the FIFO contents. uart_tx shares the same reset.
//  flit_in is ignored when flit_valid=0. Data is never altered (width DATA_W passes through).
// CONFIGURATION
//  Macro UART_TXQ_STATS_EN:
//   defined     -> tx_count increments by 1 (wraps 16'hFFFF->0) in every LOAD cycle; cleared by reset.
//   not defined -> no counter logic; tx_count is tied to 16'h0000.
// STRUCTURE
//  Package uart_txq_pkg:
//   state encoding localparams: ST_IDLE=2'd0, ST_LOAD=2'd1, ST_WAIT_BUSY=2'd2, ST_WAIT_DONE=2'd3
//   default DATA_W=16, DEPTH=8
//  Sub-module uart_txq_fifo: synchronous register-array FIFO with push/pop, count, full and empty.
//   Top level = FIFO instance + 4-state FSM + tx_data register + optional stats counter.
// TESTING (uart_tx modelled: tx_busy rises 1 cycle after new_tx_data, stays high 20 cycles)
//  1 Reset asserted mid-stream -> next cycle: count=0, empty=1, flit_ready=1, new_tx_data=0, tx_data=16'h0000.
//  2 Push 16'hABCD at edge N into an empty queue -> new_tx_data=1 for one cycle after edge N+1 with tx_data=16'hABCD.
//      count returns to 0; tx_data holds through WAIT_DONE.
//  3 Push 16'h0001..16'h0008 back-to-back with tx_busy held high -> full=1, flit_ready=0 after the 8th push.
//      A 9th push (16'h0009) is rejected; on release, outputs appear in order 0001..0008.
//  4 Push and pop in the same cycle at count=3 -> count stays 3. Run 20 flits through DEPTH=8 -> wrap-around preserves order.
//  5 Hold tx_busy=1 while a flit is pending in IDLE -> no new_tx_data pulse until tx_busy=0, then LOAD one cycle later.
//  6 UART_TXQ_STATS_EN defined, 5 flits sent -> tx_count=5. Undefined -> tx_count=0 throughout.
//  Loopback: chain with baud_gen (12'h240 / 16'h3AC9), uart_tx and uart_rx.
//      4 flits (16'h1234, 16'hABCD, 16'h0000, 16'hFFFF) are received on rx_data in order.

Source files
------------

// File: rtl/uart_txq_pkg.sv
// Shared constants for the UART flit transmit queue: FSM state encoding and default sizes.
package uart_txq_pkg;

  localparam int TXQ_DATA_W = 16;
  localparam int TXQ_DEPTH  = 8;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD      = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/uart_txq_fifo.sv
// Register-array FIFO with registered occupancy; full/empty decode the count.
module uart_txq_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [ADDR_W-1:0]            wr_ptr, rd_ptr;
  logic                         do_push, do_pop;

  assign full    = (count == (ADDR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset: contents are only observable behind a valid count.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_flit_tx_queue.sv
// Flit queue feeding uart_tx one word at a time, paced by tx_busy.
// Optional issued-flit counter enabled by defining UART_TXQ_STATS_EN.
module uart_flit_tx_queue
  import uart_txq_pkg::*;
#(
  parameter  int DATA_W = TXQ_DATA_W,
  parameter  int DEPTH  = TXQ_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] flit_in,
  input  logic              flit_valid,
  output logic              flit_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              new_tx_data,
  input  logic              tx_busy,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic [15:0]       tx_count
);

  logic [1:0]        state;
  logic [DATA_W-1:0] head;
  logic              pop;

  assign flit_ready = ~full;
  assign pop        = (state == ST_LOAD);

  uart_txq_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (flit_valid & flit_ready),
    .din   (flit_in),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // tx_data and the pulse are registered on entry to LOAD so both are valid
  // throughout the LOAD cycle; the FIFO pop lands at the end of it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      tx_data     <= '0;
      new_tx_data <= 1'b0;
    end else begin
      new_tx_data <= 1'b0;
      case (state)
        ST_IDLE: if (!empty && !tx_busy) begin
          state       <= ST_LOAD;
          tx_data     <= head;
          new_tx_data <= 1'b1;
        end
        ST_LOAD:      state <= ST_WAIT_BUSY;
        ST_WAIT_BUSY: if (tx_busy)  state <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (!tx_busy) state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

`ifdef UART_TXQ_STATS_EN
  logic [15:0] tx_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         tx_cnt_q <= '0;
    else if (pop)      tx_cnt_q <= tx_cnt_q + 16'd1;
  end

  assign tx_count = tx_cnt_q;
`else
  assign tx_count = 16'h0000;
`endif

endmodule
